// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load-use hazard inserts one bubble; a flush squashes the incoming instruction.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      id_ctrl,
  input  logic [31:0]      id_pc4,
  input  logic [31:0]      id_rd1,
  input  logic [31:0]      id_rd2,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             flush,
  output logic [10:0]      ex_ctrl,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_rd1,
  output logic [31:0]      ex_rd2,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int ALUSRC   = 1;
  localparam int MEMREAD  = 4;
  localparam int MEMWRITE = 5;

  logic uses_rt;

  // Stores read rt as data even though ALUSrc selects the immediate.
  assign uses_rt = ~id_ctrl[ALUSRC] | id_ctrl[MEMWRITE];

  assign stall = ex_ctrl[MEMREAD] & (ex_rt != 5'd0) &
                 ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt))) & ~flush;

  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl   <= '0;
      ex_pc4    <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      ex_ctrl <= (flush | stall) ? 11'd0 : id_ctrl;
      ex_pc4  <= id_pc4;
      ex_rd1  <= id_rd1;
      ex_rd2  <= id_rd2;
      ex_imm  <= id_imm;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_rd   <= id_rd;
      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a field-level reference model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] id_ctrl;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;

  logic [10:0] ex_ctrl, s_ctrl;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm, s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, s_rs, s_rt, s_rd;
  logic        stall, pc_write, ifid_write, s_stall, s_pcw, s_ifw;
  logic [15:0] stall_cnt;
  logic [1:0]  s_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // reference state: the fields of the instruction currently sitting in EX
  logic [10:0] m_ctrl;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall(stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .ex_ctrl(s_ctrl), .ex_pc4(s_pc4), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .stall(s_stall),
    .pc_write(s_pcw), .ifid_write(s_ifw), .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // Load-use rule stated in instruction terms: the load in EX writes rt,
  // the ID instruction reads rs always and rt unless it takes the immediate (stores still read rt).
  function automatic logic hazard(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic f);
    logic ex_is_load, reads_rt;
    ex_is_load = m_ctrl[4];
    reads_rt   = (c[1] == 1'b0) || (c[5] == 1'b1);
    if (f || !ex_is_load || m_rt == 5'd0) return 1'b0;
    return (m_rt == rs) || (reads_rt && m_rt == rt);
  endfunction

  task automatic cyc(input logic [10:0] c, input logic [31:0] p, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] im, input logic [4:0] s,
                     input logic [4:0] t, input logic [4:0] d, input logic f,
                     output logic st_obs);
    logic exp_st;
    @(negedge clk);
    id_ctrl = c; id_pc4 = p; id_rd1 = a; id_rd2 = b; id_imm = im;
    id_rs = s; id_rt = t; id_rd = d; flush = f;
    #1;
    exp_st = hazard(c, s, t, f);
    st_obs = stall;
    chk("stall", {31'd0, stall}, {31'd0, exp_st});
    chk("pc_write", {31'd0, pc_write}, {31'd0, !exp_st});
    chk("ifid_write", {31'd0, ifid_write}, {31'd0, !exp_st});
    chk("stall_w2", {31'd0, s_stall}, {31'd0, exp_st});
    @(posedge clk);
    #1;
    m_ctrl = (f || exp_st) ? 11'd0 : c;
    m_pc4 = p; m_rd1 = a; m_rd2 = b; m_imm = im; m_rs = s; m_rt = t; m_rd = d;
    if (exp_st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    chk("ex_ctrl", {21'd0, ex_ctrl}, {21'd0, m_ctrl});
    chk("ex_data", ex_pc4 ^ ex_rd1 ^ {ex_rd2[15:0], ex_rd2[31:16]} ^ ex_imm,
        m_pc4 ^ m_rd1 ^ {m_rd2[15:0], m_rd2[31:16]} ^ m_imm);
    chk("ex_rd1", ex_rd1, m_rd1);
    chk("ex_regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m_rs, m_rt, m_rd});
    chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    chk("stall_cnt_w2", {30'd0, s_cnt}, m_cnt2);
    chk("ex_ctrl_w2", {21'd0, s_ctrl}, {21'd0, m_ctrl});
  endtask

  localparam logic [10:0] RTYPE = 11'h04B;
  localparam logic [10:0] LW    = 11'h01E;
  localparam logic [10:0] ADDIU = 11'h00A;

  initial begin
    logic st;
    rst_n = 1'b0;
    id_ctrl = '0; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0;
    model_reset();
    #12;
    chk("rst_ctrl", {21'd0, ex_ctrl}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_pcw", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // pass-through
    cyc(RTYPE, 32'h40, 32'h1234, 32'h55, 32'h9, 5'd1, 5'd2, 5'd3, 1'b0, st);
    chk("pt_ctrl", {21'd0, ex_ctrl}, 32'h04B);
    chk("pt_rd1", ex_rd1, 32'h1234);
    chk("pt_stall", {31'd0, st}, 32'd0);

    // load-use: exactly one bubble
    cyc(LW, 32'h44, 32'h0, 32'h0, 32'h8, 5'd2, 5'd5, 5'd0, 1'b0, st);
    cyc(RTYPE, 32'h48, 32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd7, 1'b0, st);
    chk("lu_stall", {31'd0, st}, 32'd1);
    chk("lu_bubble", {21'd0, ex_ctrl}, 32'd0);
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    cyc(RTYPE, 32'h48, 32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd7, 1'b0, st);
    chk("lu_release", {31'd0, st}, 32'd0);

    // immediate-form consumer does not read rt
    cyc(LW, 32'h4c, 32'h0, 32'h0, 32'h4, 5'd1, 5'd7, 5'd0, 1'b0, st);
    cyc(ADDIU, 32'h50, 32'h0, 32'h0, 32'h4, 5'd3, 5'd7, 5'd0, 1'b0, st);
    chk("nort_stall", {31'd0, st}, 32'd0);

    // flush beats stall
    cyc(LW, 32'h54, 32'h0, 32'h0, 32'h4, 5'd1, 5'd5, 5'd0, 1'b0, st);
    cyc(RTYPE, 32'h58, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd1, 1'b1, st);
    chk("fl_stall", {31'd0, st}, 32'd0);
    chk("fl_ctrl", {21'd0, ex_ctrl}, 32'd0);
    chk("fl_cnt", {16'd0, stall_cnt}, 32'd1);

    // asynchronous reset mid-cycle
    cyc(11'h0FF, 32'h5c, 32'h3, 32'h3, 32'h3, 5'd4, 5'd4, 5'd4, 1'b0, st);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ctrl", {21'd0, ex_ctrl}, 32'd0);
    chk("arst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst_pcw", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation on the 2-bit counter: four stall edges
    for (int k = 0; k < 4; k++) begin
      cyc(LW, 32'h60, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 1'b0, st);
      cyc(RTYPE, 32'h64, 32'h0, 32'h0, 32'h0, 5'd9, 5'd1, 5'd2, 1'b0, st);
    end
    chk("sat_cnt", {30'd0, s_cnt}, 32'd3);
    chk("sat_cnt16", {16'd0, stall_cnt}, 32'd4);

    // random traffic with narrow register numbers so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      logic [10:0] c;
      c = 11'($urandom);
      c[4] = ($urandom_range(0, 1) == 1);
      cyc(c, $urandom, $urandom, $urandom, $urandom,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 7) == 0), st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
